// File: rtl/spi_slave_byte.sv
// SPI mode-0 byte-level slave: oversampled SCK/CS_n/MOSI, valid/ready rx and tx byte ports.
// Optional SPI_SLAVE_OVERRUN_EN: drop bytes on overrun and expose rx_ovr / ovr_cnt.
module spi_slave_byte #(
   parameter logic [7:0] DEFAULT_TX = 8'hFF
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       spi_sck_i,
   input  logic       spi_cs_n_i,
   input  logic       spi_mosi_i,
   output logic       spi_miso_o,
   output logic       spi_miso_oe,
   input  logic [7:0] wdata,
   input  logic       wvalid,
   output logic       wready,
   output logic [7:0] rdata,
   output logic       rvalid,
   input  logic       rready,
`ifdef SPI_SLAVE_OVERRUN_EN
   output logic       rx_ovr,
   output logic [7:0] ovr_cnt,
`endif
   output logic       busy
);

   localparam logic [0:0] ST_IDLE   = 1'b0;
   localparam logic [0:0] ST_ACTIVE = 1'b1;

   // Stage 0/1 form the synchronizer, stage 2 is the edge-detect history.
   logic [2:0] sck_q, sck_d;
   logic [2:0] cs_n_q, cs_n_d;
   logic [2:0] mosi_q, mosi_d;

   logic [0:0] state_q, state_d;
   logic [2:0] bit_cnt_q, bit_cnt_d;
   logic [7:0] tx_sr_q, tx_sr_d;
   logic [7:0] rx_sr_q, rx_sr_d;
   logic [7:0] stage_q, stage_d;
   logic [7:0] hold_q, hold_d;
   logic       hold_full_q, hold_full_d;
   logic       miso_q, miso_d;
   logic       miso_oe_q, miso_oe_d;
   logic [7:0] rdata_q, rdata_d;
   logic       rvalid_q, rvalid_d;
`ifdef SPI_SLAVE_OVERRUN_EN
   logic       rx_ovr_q, rx_ovr_d;
   logic [7:0] ovr_cnt_q, ovr_cnt_d;
`endif

   logic       sck_rise, sck_fall, cs_fall, cs_rise;
   logic       byte_done;
   logic [7:0] rx_byte;
   logic [7:0] next_tx;

   always_comb begin
      sck_d    = {sck_q[1:0], spi_sck_i};
      cs_n_d   = {cs_n_q[1:0], spi_cs_n_i};
      mosi_d   = {mosi_q[1:0], spi_mosi_i};
      sck_rise = sck_q[1] & ~sck_q[2];
      sck_fall = ~sck_q[1] & sck_q[2];
      cs_fall  = ~cs_n_q[1] & cs_n_q[2];
      cs_rise  = cs_n_q[1] & ~cs_n_q[2];
      rx_byte  = {rx_sr_q[6:0], mosi_q[1]};
      next_tx  = hold_full_q ? hold_q : DEFAULT_TX;
   end

   always_comb begin
      // NOTE: every _d starts at its _q value so no path through this block can infer a latch.
      state_d     = state_q;
      bit_cnt_d   = bit_cnt_q;
      tx_sr_d     = tx_sr_q;
      rx_sr_d     = rx_sr_q;
      stage_d     = stage_q;
      hold_d      = hold_q;
      hold_full_d = hold_full_q;
      miso_d      = miso_q;
      miso_oe_d   = miso_oe_q;
      rdata_d     = rdata_q;
      rvalid_d    = rvalid_q;
      byte_done   = 1'b0;
`ifdef SPI_SLAVE_OVERRUN_EN
      rx_ovr_d    = 1'b0;
      ovr_cnt_d   = ovr_cnt_q;
`endif

      if (rvalid_q && rready) rvalid_d = 1'b0;

      // Writes only land when empty, so they can never collide with a consume below.
      if (wvalid && !hold_full_q) begin
         hold_d      = wdata;
         hold_full_d = 1'b1;
      end

      case (state_q)
         ST_IDLE: begin
            if (cs_fall) begin
               state_d     = ST_ACTIVE;
               tx_sr_d     = next_tx;
               miso_d      = next_tx[7];
               miso_oe_d   = 1'b1;
               bit_cnt_d   = 3'd0;
               if (hold_full_q) hold_full_d = 1'b0;
            end
         end
         default: begin
            if (cs_rise) begin
               state_d   = ST_IDLE;
               bit_cnt_d = 3'd0;
               miso_oe_d = 1'b0;
               miso_d    = 1'b1;
            end else if (sck_rise) begin
               rx_sr_d   = rx_byte;
               bit_cnt_d = bit_cnt_q + 3'd1;
               if (bit_cnt_q == 3'd7) begin
                  byte_done = 1'b1;
                  stage_d   = next_tx;
                  if (hold_full_q) hold_full_d = 1'b0;
               end
            end else if (sck_fall) begin
               // bit_cnt==0 on a fall means a byte just finished: switch to the staged byte.
               if (bit_cnt_q != 3'd0) begin
                  tx_sr_d = {tx_sr_q[6:0], 1'b0};
                  miso_d  = tx_sr_q[6];
               end else begin
                  tx_sr_d = stage_q;
                  miso_d  = stage_q[7];
               end
            end
         end
      endcase

      if (byte_done) begin
`ifdef SPI_SLAVE_OVERRUN_EN
         if (rvalid_q && !rready) begin
            rx_ovr_d = 1'b1;
            if (ovr_cnt_q != 8'hFF) ovr_cnt_d = ovr_cnt_q + 8'd1;
         end else begin
            rdata_d  = rx_byte;
            rvalid_d = 1'b1;
         end
`else
         rdata_d  = rx_byte;
         rvalid_d = 1'b1;
`endif
      end
   end

   // NOTE: sequential state uses non-blocking assignments only, so every flop sees pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sck_q       <= 3'b000;
         cs_n_q      <= 3'b111;
         mosi_q      <= 3'b000;
         state_q     <= ST_IDLE;
         bit_cnt_q   <= 3'd0;
         tx_sr_q     <= 8'd0;
         rx_sr_q     <= 8'd0;
         stage_q     <= 8'd0;
         hold_q      <= 8'd0;
         hold_full_q <= 1'b0;
         miso_q      <= 1'b1;
         miso_oe_q   <= 1'b0;
         rdata_q     <= 8'd0;
         rvalid_q    <= 1'b0;
`ifdef SPI_SLAVE_OVERRUN_EN
         rx_ovr_q    <= 1'b0;
         ovr_cnt_q   <= 8'd0;
`endif
      end else begin
         sck_q       <= sck_d;
         cs_n_q      <= cs_n_d;
         mosi_q      <= mosi_d;
         state_q     <= state_d;
         bit_cnt_q   <= bit_cnt_d;
         tx_sr_q     <= tx_sr_d;
         rx_sr_q     <= rx_sr_d;
         stage_q     <= stage_d;
         hold_q      <= hold_d;
         hold_full_q <= hold_full_d;
         miso_q      <= miso_d;
         miso_oe_q   <= miso_oe_d;
         rdata_q     <= rdata_d;
         rvalid_q    <= rvalid_d;
`ifdef SPI_SLAVE_OVERRUN_EN
         rx_ovr_q    <= rx_ovr_d;
         ovr_cnt_q   <= ovr_cnt_d;
`endif
      end
   end

   assign spi_miso_o  = miso_q;
   assign spi_miso_oe = miso_oe_q;
   assign wready      = ~hold_full_q;
   assign rdata       = rdata_q;
   assign rvalid      = rvalid_q;
   assign busy        = (state_q == ST_ACTIVE);
`ifdef SPI_SLAVE_OVERRUN_EN
   assign rx_ovr      = rx_ovr_q;
   assign ovr_cnt     = ovr_cnt_q;
`endif

endmodule

// File: tb/tb_spi_slave_byte.sv
// Self-checking bench for spi_slave_byte: bit-banged mode-0 master (SCK = clk/8) with rx/miso scoreboards.
module tb_spi_slave_byte;

   logic       clk = 1'b0;
   logic       rst;
   logic       spi_sck_i, spi_cs_n_i, spi_mosi_i;
   logic       spi_miso_o, spi_miso_oe;
   logic [7:0] wdata;
   logic       wvalid, wready;
   logic [7:0] rdata;
   logic       rvalid, rready;
   logic       busy;
`ifdef SPI_SLAVE_OVERRUN_EN
   logic       rx_ovr;
   logic [7:0] ovr_cnt;
`endif

   int n_total = 0;
   int n_bad   = 0;
   int ovr_pulses = 0;
   logic [7:0] rx_q[$];
   logic [7:0] miso_q[$];

   always #5 clk = ~clk;

   spi_slave_byte #(.DEFAULT_TX(8'hFF)) dut (
      .clk(clk), .rst(rst),
      .spi_sck_i(spi_sck_i), .spi_cs_n_i(spi_cs_n_i), .spi_mosi_i(spi_mosi_i),
      .spi_miso_o(spi_miso_o), .spi_miso_oe(spi_miso_oe),
      .wdata(wdata), .wvalid(wvalid), .wready(wready),
      .rdata(rdata), .rvalid(rvalid), .rready(rready),
`ifdef SPI_SLAVE_OVERRUN_EN
      .rx_ovr(rx_ovr), .ovr_cnt(ovr_cnt),
`endif
      .busy(busy)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Consumer side of the rx scoreboard: one comparison per accepted byte.
   always @(negedge clk) begin
      if (!rst && rvalid && rready) begin
         check("rx_expected_pending", rx_q.size() > 0, 1);
         if (rx_q.size() > 0) check("rdata", rdata, rx_q.pop_front());
      end
`ifdef SPI_SLAVE_OVERRUN_EN
      if (!rst && rx_ovr) ovr_pulses++;
`endif
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic push_tx(input logic [7:0] b);
      int i = 0;
      while (!wready && i < 50) begin
         @(negedge clk);
         i++;
      end
      check("wready_wait", wready, 1);
      wdata  = b;
      wvalid = 1'b1;
      @(negedge clk);
      wvalid = 1'b0;
   endtask

   task automatic cs_begin();
      spi_cs_n_i = 1'b0;
      repeat (8) @(negedge clk);
   endtask

   task automatic cs_end();
      repeat (4) @(negedge clk);
      spi_cs_n_i = 1'b1;
      repeat (8) @(negedge clk);
   endtask

   // Mode 0: MOSI changes with SCK low, both sides sample on SCK rise.
   task automatic spi_bits(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
      rx = 8'h00;
      for (int i = 7; i > 7 - nbits; i--) begin
         spi_mosi_i = tx[i];
         repeat (4) @(negedge clk);
         rx[i] = spi_miso_o;
         spi_sck_i = 1'b1;
         repeat (4) @(negedge clk);
         spi_sck_i = 1'b0;
      end
   endtask

   task automatic xfer(input logic [7:0] tx);
      logic [7:0] got;
      spi_bits(tx, 8, got);
      check("miso_expected_pending", miso_q.size() > 0, 1);
      if (miso_q.size() > 0) check("miso_byte", got, miso_q.pop_front());
   endtask

   task automatic check_reset_values();
      check("rst_miso", spi_miso_o, 1);
      check("rst_miso_oe", spi_miso_oe, 0);
      check("rst_wready", wready, 1);
      check("rst_rdata", rdata, 0);
      check("rst_rvalid", rvalid, 0);
      check("rst_busy", busy, 0);
   endtask

   initial begin
      logic [7:0] dummy;
      rst = 1'b1;
      spi_sck_i = 1'b0; spi_cs_n_i = 1'b1; spi_mosi_i = 1'b0;
      wdata = 8'h00; wvalid = 1'b0; rready = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      repeat (2) @(negedge clk);
      check_reset_values();

      // Single byte with preloaded tx.
      push_tx(8'hA5);
      check("wready_after_write", wready, 0);
      miso_q.push_back(8'hA5);
      rx_q.push_back(8'h9F);
      cs_begin();
      check("busy_active", busy, 1);
      check("miso_oe_active", spi_miso_oe, 1);
      check("wready_after_consume", wready, 1);
      xfer(8'h9F);
      cs_end();
      check("busy_idle", busy, 0);
      check("miso_oe_idle", spi_miso_oe, 0);

      // Back-to-back bytes, tx underruns on the third.
      push_tx(8'hA1);
      cs_begin();
      push_tx(8'hB2);
      miso_q.push_back(8'hA1); miso_q.push_back(8'hB2); miso_q.push_back(8'hFF);
      rx_q.push_back(8'h9F); rx_q.push_back(8'hFF); rx_q.push_back(8'hFF);
      xfer(8'h9F); xfer(8'hFF); xfer(8'hFF);
      cs_end();

      // Nothing written: DEFAULT_TX.
      miso_q.push_back(8'hFF);
      rx_q.push_back(8'h3C);
      cs_begin();
      xfer(8'h3C);
      cs_end();

      // Aborted partial byte, then realignment.
      cs_begin();
      spi_bits(8'hF0, 3, dummy);
      cs_end();
      check("partial_no_rvalid", rvalid, 0);
      miso_q.push_back(8'hFF);
      rx_q.push_back(8'h55);
      cs_begin();
      xfer(8'h55);
      cs_end();

      // Overrun with consumer stalled.
      rready = 1'b0;
      miso_q.push_back(8'hFF); miso_q.push_back(8'hFF);
      cs_begin();
      xfer(8'h11); xfer(8'h22);
      cs_end();
      check("ovr_rvalid_held", rvalid, 1);
`ifdef SPI_SLAVE_OVERRUN_EN
      check("ovr_rdata_kept", rdata, 8'h11);
      check("ovr_cnt", ovr_cnt, 1);
      check("ovr_pulses", ovr_pulses, 1);
      rx_q.push_back(8'h11);
`else
      check("ovr_rdata_overwritten", rdata, 8'h22);
      rx_q.push_back(8'h22);
`endif
      rready = 1'b1;
      repeat (3) @(negedge clk);
      check("ovr_rvalid_cleared", rvalid, 0);

      // Async reset in the middle of a byte with the holding register full.
      cs_begin();
      push_tx(8'h5A);
      spi_bits(8'hC3, 4, dummy);
      check("wready_full", wready, 0);
      rst = 1'b1; spi_cs_n_i = 1'b1; spi_sck_i = 1'b0;
      #1;
      check_reset_values();
      @(negedge clk);
      rst = 1'b0;
      repeat (8) @(negedge clk);
      miso_q.push_back(8'hFF);
      rx_q.push_back(8'h81);
      cs_begin();
      xfer(8'h81);
      cs_end();

      repeat (10) @(negedge clk);
      check("rx_scoreboard_drained", rx_q.size(), 0);
      check("miso_scoreboard_drained", miso_q.size(), 0);
      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
